// File: rtl/bit_window_unpacker.sv
// Streams 32-bit words into a two-slot bit buffer and emits WIN_W-bit windows from an advancing bit pointer.
// Optional window counter on stat_win is enabled by defining BIT_WINDOW_UNPACKER_STATS_EN.
module bit_window_unpacker #(
    parameter int WORD_W = 32,
    parameter int WIN_W  = 8,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic [STEP_W-1:0] step,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIN_W-1:0]  out_data,
    output logic [15:0]       stat_win
);

    localparam int BUF_W = 2 * WORD_W;
    localparam int PTR_W = $clog2(BUF_W);
    localparam int CNT_W = PTR_W + 1;

    // Handshakes: a word moves when in_valid & in_ready; a window moves when out_valid & out_ready.
    // flush overrides both, so neither side observes a transfer in a flush cycle.

    logic [BUF_W-1:0]   r_buf;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic [2*BUF_W-1:0] w_dbl;
    logic [PTR_W-1:0]   w_wr_ptr;
    logic               w_wr_slot;
    logic               w_in_fire;
    logic               w_out_fire;
    logic [CNT_W-1:0]   w_eff_step;
    logic [CNT_W-1:0]   w_count_nxt;
    logic [PTR_W-1:0]   w_rd_ptr_nxt;

    assign in_ready  = (r_count <= CNT_W'(WORD_W));
    assign out_valid = (r_count >= CNT_W'(WIN_W));

    // Doubling the buffer lets a window that runs past the top bit wrap to bit 0 without muxing.
    assign w_dbl    = {r_buf, r_buf};
    assign out_data = w_dbl[{1'b0, r_rd_ptr} +: WIN_W];

    assign w_in_fire  = in_valid & in_ready & ~flush;
    assign w_out_fire = out_valid & out_ready & ~flush;

    // Fill level plus read pointer always lands on a slot boundary, which names the free slot.
    assign w_wr_ptr  = r_rd_ptr + r_count[PTR_W-1:0];
    assign w_wr_slot = (w_wr_ptr >= PTR_W'(WORD_W));

    always_comb begin
        w_eff_step = CNT_W'(step);
        if (step == '0) begin
            w_eff_step = CNT_W'(1);
        end else if (32'(step) > 32'(WIN_W)) begin
            w_eff_step = CNT_W'(WIN_W);
        end
    end

    always_comb begin
        w_count_nxt  = r_count;
        w_rd_ptr_nxt = r_rd_ptr;
        if (w_in_fire) begin
            w_count_nxt = w_count_nxt + CNT_W'(WORD_W);
        end
        if (w_out_fire) begin
            w_count_nxt  = w_count_nxt - w_eff_step;
            w_rd_ptr_nxt = r_rd_ptr + w_eff_step[PTR_W-1:0];
        end
        if (flush) begin
            w_count_nxt  = '0;
            w_rd_ptr_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_count  <= w_count_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
        end
    end

    // Only the free slot is written, so a window held under backpressure never changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf <= '0;
        end else if (w_in_fire) begin
            if (w_wr_slot) begin
                r_buf[BUF_W-1:WORD_W] <= in_data;
            end else begin
                r_buf[WORD_W-1:0] <= in_data;
            end
        end
    end

`ifdef BIT_WINDOW_UNPACKER_STATS_EN
    logic [15:0] r_stat_win;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_win <= '0;
        end else if (w_out_fire && (r_stat_win != 16'hFFFF)) begin
            r_stat_win <= r_stat_win + 16'd1;
        end
    end

    assign stat_win = r_stat_win;
`else
    assign stat_win = '0;
`endif

endmodule

// File: tb/tb_bit_window_unpacker.sv
// Directed, table-driven bench for bit_window_unpacker; expected windows are hand-computed per cycle.
// Stats checks follow BIT_WINDOW_UNPACKER_STATS_EN when it is defined for the build.
module tb_bit_window_unpacker;

    localparam int WORD_W = 32;
    localparam int WIN_W  = 8;
    localparam int STEP_W = 4;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;
    logic [STEP_W-1:0] step;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [WIN_W-1:0]  out_data;
    logic [15:0]       stat_win;

    bit_window_unpacker #(
        .WORD_W(WORD_W),
        .WIN_W (WIN_W),
        .STEP_W(STEP_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .step     (step),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .stat_win (stat_win)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One record per cycle: inputs driven for the cycle, outputs expected before its rising edge.
    typedef struct {
        logic              iv;
        logic [WORD_W-1:0] din;
        logic [STEP_W-1:0] st;
        logic              fl;
        logic              ordy;
        logic              e_ov;
        logic              e_ir;
        logic [WIN_W-1:0]  e_od;
    } vec_t;

    vec_t             vecs[$];
    logic [WIN_W-1:0] exp_q[$];
    int               n_cmp  = 0;
    int               n_fail = 0;

    function automatic vec_t mk(input logic iv, input logic [WORD_W-1:0] din, input logic [STEP_W-1:0] st,
                                input logic fl, input logic ordy, input logic e_ov, input logic e_ir,
                                input logic [WIN_W-1:0] e_od);
        vec_t v;
        v.iv = iv; v.din = din; v.st = st; v.fl = fl; v.ordy = ordy;
        v.e_ov = e_ov; v.e_ir = e_ir; v.e_od = e_od;
        return v;
    endfunction

    function automatic void add(input logic iv, input logic [WORD_W-1:0] din, input logic [STEP_W-1:0] st,
                                input logic fl, input logic ordy, input logic e_ov, input logic e_ir,
                                input logic [WIN_W-1:0] e_od);
        vecs.push_back(mk(iv, din, st, fl, ordy, e_ov, e_ir, e_od));
    endfunction

    // Scoreboard
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Driver: present one vector at the falling edge, check, then let the rising edge take it.
    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        in_valid  = v.iv;
        in_data   = v.din;
        step      = v.st;
        flush     = v.fl;
        out_ready = v.ordy;
        #1;
        chk({tag, " out_valid"}, 32'(out_valid), 32'(v.e_ov));
        chk({tag, " in_ready"},  32'(in_ready),  32'(v.e_ir));
        chk({tag, " out_data"},  32'(out_data),  32'(v.e_od));
        if (v.e_ov && v.ordy && !v.fl) exp_q.push_back(v.e_od);
        if (out_valid && out_ready && !flush) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL %s accept: got window %h, expected no accept", tag, out_data);
            end else begin
                chk({tag, " accepted window"}, 32'(out_data), 32'(exp_q.pop_front()));
            end
        end
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        in_data   = '0;
        step      = 4'd8;
        flush     = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        idle();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset in_ready",  32'(in_ready),  32'd1);
        chk("reset out_data",  32'(out_data),  32'd0);
        chk("reset stat_win",  32'(stat_win),  32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // byte-aligned windows from one word
        add(H, 32'hA5C3_0F81, 4'd8, L, H, L, H, 8'h00);
        add(L, 32'h0,         4'd8, L, H, H, H, 8'h81);
        add(L, 32'h0,         4'd8, L, H, H, H, 8'h0F);
        add(L, 32'h0,         4'd8, L, H, H, H, 8'hC3);
        add(L, 32'h0,         4'd8, L, H, H, H, 8'hA5);
        add(L, 32'h0,         4'd8, L, H, L, H, 8'h00);
        // nibble steps into the upper slot, tail of 4 bits, then a wrapping window
        add(H, 32'h8765_4321, 4'd4, L, L, L, H, 8'h00);
        add(L, 32'h0,         4'd4, L, H, H, H, 8'h21);
        add(L, 32'h0,         4'd4, L, H, H, H, 8'h32);
        add(L, 32'h0,         4'd4, L, H, H, H, 8'h43);
        add(L, 32'h0,         4'd4, L, H, H, H, 8'h54);
        add(L, 32'h0,         4'd4, L, H, H, H, 8'h65);
        add(L, 32'h0,         4'd4, L, H, H, H, 8'h76);
        add(L, 32'h0,         4'd4, L, H, H, H, 8'h87);
        add(H, 32'h0000_000A, 4'd4, L, L, L, H, 8'h18);
        add(L, 32'h0,         4'd8, L, L, H, L, 8'hA8);
        add(L, 32'h0,         4'd8, L, L, H, L, 8'hA8);
        add(L, 32'h0,         4'd8, L, H, H, L, 8'hA8);
        add(L, 32'h0,         4'd8, H, H, H, H, 8'h00);
        // full buffer under backpressure: third word refused, window stable
        add(H, 32'h1122_3344, 4'd8, L, L, L, H, 8'h0A);
        add(H, 32'h5566_7788, 4'd8, L, L, H, H, 8'h44);
        for (int i = 0; i < 5; i++) add(H, 32'h99AA_BBCC, 4'd8, L, L, H, L, 8'h44);
        add(L, 32'h0,         4'd8, L, H, H, L, 8'h44);
        add(H, 32'hDEAD_BEEF, 4'd8, L, H, H, L, 8'h33);
        add(L, 32'h0,         4'd8, L, H, H, L, 8'h22);
        add(L, 32'h0,         4'd8, L, H, H, L, 8'h11);
        add(L, 32'h0,         4'd8, L, H, H, H, 8'h88);
        add(L, 32'h0,         4'd8, H, L, H, H, 8'h77);
        // step 5 across both slots, refill slot 0 during a take, window across bit 63 -> 0
        add(H, 32'h1234_5678, 4'd5, L, L, L, H, 8'h44);
        add(H, 32'h9ABC_DEF0, 4'd5, L, L, H, H, 8'h78);
        add(L, 32'h0,         4'd5, L, H, H, L, 8'h78);
        add(L, 32'h0,         4'd5, L, H, H, L, 8'hB3);
        add(L, 32'h0,         4'd5, L, H, H, L, 8'h15);
        add(L, 32'h0,         4'd5, L, H, H, L, 8'h68);
        add(L, 32'h0,         4'd5, L, H, H, L, 8'h23);
        add(L, 32'h0,         4'd5, L, H, H, L, 8'h09);
        add(L, 32'h0,         4'd5, L, H, H, L, 8'hC0);
        add(H, 32'hFFFF_FFFF, 4'd5, L, H, H, H, 8'hDE);
        add(L, 32'h0,         4'd5, L, H, H, L, 8'hDE);
        add(L, 32'h0,         4'd5, L, H, H, L, 8'hE6);
        add(L, 32'h0,         4'd5, L, H, H, L, 8'hAF);
        add(L, 32'h0,         4'd5, L, H, H, L, 8'h35);
        add(L, 32'h0,         4'd5, L, H, H, L, 8'hF9);
        add(H, 32'h0,         4'd5, H, H, H, H, 8'hFF);
        add(L, 32'h0,         4'd5, L, L, L, H, 8'hFF);
        // step clamp, flush at count 20 with a dropped word, step 0 advancing one bit
        add(H, 32'h0F0F_0F0F, 4'd8,  L, L, L, H, 8'hFF);
        add(L, 32'h0,         4'd12, L, H, H, H, 8'h0F);
        add(L, 32'h0,         4'd4,  L, H, H, H, 8'h0F);
        add(H, 32'hAAAA_AAAA, 4'd8,  H, H, H, H, 8'hF0);
        add(L, 32'h0,         4'd8,  L, L, L, H, 8'h0F);
        add(H, 32'h8765_4321, 4'd0,  L, L, L, H, 8'h0F);
        add(L, 32'h0,         4'd0,  L, H, H, H, 8'h21);
        add(L, 32'h0,         4'd0,  L, H, H, H, 8'h90);
        add(L, 32'h0,         4'd15, L, H, H, H, 8'hC8);
        add(L, 32'h0,         4'd8,  L, L, H, H, 8'h50);

        foreach (vecs[i]) apply(vecs[i], $sformatf("v%0d", i));

        // asynchronous reset between edges while a word is being offered
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = 32'hCAFE_F00D;
        out_ready = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        chk("async reset out_valid", 32'(out_valid), 32'd0);
        chk("async reset in_ready",  32'(in_ready),  32'd1);
        chk("async reset out_data",  32'(out_data),  32'd0);
        chk("async reset stat_win",  32'(stat_win),  32'd0);
        @(negedge clk);
        chk("held reset out_valid", 32'(out_valid), 32'd0);
        chk("held reset out_data",  32'(out_data),  32'd0);
        idle();
        rst_n = 1'b1;

        apply(mk(H, 32'h0102_0304, 4'd8, L, L, L, H, 8'h00), "r0");
        apply(mk(L, 32'h0,         4'd8, L, H, H, H, 8'h04), "r1");
        apply(mk(L, 32'h0,         4'd8, L, H, H, H, 8'h03), "r2");
        apply(mk(L, 32'h0,         4'd8, L, H, H, H, 8'h02), "r3");
        apply(mk(L, 32'h0,         4'd8, L, H, H, H, 8'h01), "r4");
        apply(mk(L, 32'h0,         4'd8, L, L, L, H, 8'h00), "r5");
`ifdef BIT_WINDOW_UNPACKER_STATS_EN
        chk("stat_win after 4 windows", 32'(stat_win), 32'd4);
`else
        chk("stat_win tied off", 32'(stat_win), 32'd0);
`endif
        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);

        idle();
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
